// File: rtl/seg_ctrl_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package seg_ctrl_pkg;

   typedef enum logic [1:0] {
      LIVE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } seg_state_t;

   localparam int unsigned SEG_DIGITS = 8;
   localparam logic [SEG_DIGITS-1:0] SEG_BLANK_VALID = 8'h00;

   // Counter width able to hold 0..max_count-1, never narrower than 1 bit.
   function automatic int unsigned cnt_width(input int unsigned max_count);
      return (max_count > 1) ? $clog2(max_count) : 1;
   endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Tick prescaler: counts 0..TICK_DIV-1 and flags the last count as a tick.
module seg_tick_gen
   import seg_ctrl_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CNT_W = cnt_width(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CNT_LAST);

   // Next count: restart forces zero, otherwise wrap after the last count.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart || tick) begin
         cnt_d = '0;
      end
   end

   // Prescaler count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seg_display_sched.sv
// Display scheduler: live pass-through, pre-empted by timed (optionally
// blinking) messages followed by a blank gap.
module seg_display_sched
   import seg_ctrl_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 100000,
   parameter int unsigned HOLD_TICKS  = 2000,
   parameter int unsigned BLINK_TICKS = 250,
   parameter int unsigned GAP_TICKS   = 100
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SEG_DIGITS*4-1:0] live_data,
   input  logic [SEG_DIGITS-1:0]   live_valid,
   input  logic                    msg_req,
   input  logic [SEG_DIGITS*4-1:0] msg_data,
   input  logic [SEG_DIGITS-1:0]   msg_valid,
   input  logic                    msg_blink,
   input  logic                    msg_cancel,
   output logic                    msg_ack,
   output logic                    msg_done,
   output logic                    msg_busy,
   output logic [SEG_DIGITS*4-1:0] output_data,
   output logic [SEG_DIGITS-1:0]   output_valid
);

   localparam int unsigned HOLD_W  = cnt_width(HOLD_TICKS);
   localparam int unsigned BLINK_W = cnt_width(BLINK_TICKS);
   localparam int unsigned GAP_W   = cnt_width(GAP_TICKS);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
   localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);

   seg_state_t state_q, state_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               blink_off_q, blink_off_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [SEG_DIGITS*4-1:0] msg_data_q, msg_data_d;
   logic [SEG_DIGITS-1:0]   msg_valid_q, msg_valid_d;
   logic                    msg_blink_q, msg_blink_d;
   logic                    msg_ack_q, msg_ack_d;
   logic                    msg_done_q, msg_done_d;
   logic                    msg_busy_q, msg_busy_d;
   logic [SEG_DIGITS*4-1:0] output_data_q, output_data_d;
   logic [SEG_DIGITS-1:0]   output_valid_q, output_valid_d;
   logic                    restart;
   logic                    tick;

   assign restart = (state_d != state_q);

   seg_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   // Next state, counters, message latch and registered outputs.
   always_comb begin
      state_d        = state_q;
      hold_d         = hold_q;
      blink_cnt_d    = blink_cnt_q;
      blink_off_d    = blink_off_q;
      gap_d          = gap_q;
      msg_data_d     = msg_data_q;
      msg_valid_d    = msg_valid_q;
      msg_blink_d    = msg_blink_q;
      msg_ack_d      = 1'b0;
      msg_done_d     = 1'b0;
      output_data_d  = live_data;
      output_valid_d = live_valid;

      case (state_q)
         LIVE: begin
            if (msg_req) begin
               state_d     = SHOW;
               msg_data_d  = msg_data;
               msg_valid_d = msg_valid;
               msg_blink_d = msg_blink;
               msg_ack_d   = 1'b1;
            end
         end
         SHOW: begin
            if (msg_cancel || (tick && hold_q == HOLD_LAST)) begin
               state_d    = (GAP_TICKS == 0) ? LIVE : GAP;
               msg_done_d = 1'b1;
            end else if (tick) begin
               hold_d = hold_q + 1'b1;
               if (msg_blink_q) begin
                  if (blink_cnt_q == BLINK_LAST) begin
                     blink_cnt_d = '0;
                     blink_off_d = ~blink_off_q;
                  end else begin
                     blink_cnt_d = blink_cnt_q + 1'b1;
                  end
               end
            end
         end
         GAP: begin
            if (tick && gap_q == GAP_LAST) begin
               state_d = LIVE;
            end else if (tick) begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = LIVE;
      endcase

      if (restart) begin
         hold_d      = '0;
         blink_cnt_d = '0;
         blink_off_d = 1'b0;
         gap_d       = '0;
      end

      // Returning to LIVE with a request already waiting keeps the display
      // blank for that one cycle so live data never flashes between messages.
      case (state_d)
         LIVE: begin
            if (state_q != LIVE && msg_req) begin
               output_data_d  = msg_data_q;
               output_valid_d = SEG_BLANK_VALID;
            end
         end
         SHOW: begin
            output_data_d  = msg_data_d;
            output_valid_d = blink_off_d ? SEG_BLANK_VALID : msg_valid_d;
         end
         default: begin
            output_data_d  = msg_data_q;
            output_valid_d = SEG_BLANK_VALID;
         end
      endcase

      msg_busy_d = (state_d != LIVE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= LIVE;
         hold_q         <= '0;
         blink_cnt_q    <= '0;
         blink_off_q    <= 1'b0;
         gap_q          <= '0;
         msg_data_q     <= '0;
         msg_valid_q    <= '0;
         msg_blink_q    <= 1'b0;
         msg_ack_q      <= 1'b0;
         msg_done_q     <= 1'b0;
         msg_busy_q     <= 1'b0;
         output_data_q  <= '0;
         output_valid_q <= '0;
      end else begin
         state_q        <= state_d;
         hold_q         <= hold_d;
         blink_cnt_q    <= blink_cnt_d;
         blink_off_q    <= blink_off_d;
         gap_q          <= gap_d;
         msg_data_q     <= msg_data_d;
         msg_valid_q    <= msg_valid_d;
         msg_blink_q    <= msg_blink_d;
         msg_ack_q      <= msg_ack_d;
         msg_done_q     <= msg_done_d;
         msg_busy_q     <= msg_busy_d;
         output_data_q  <= output_data_d;
         output_valid_q <= output_valid_d;
      end
   end

   assign msg_ack      = msg_ack_q;
   assign msg_done     = msg_done_q;
   assign msg_busy     = msg_busy_q;
   assign output_data  = output_data_q;
   assign output_valid = output_valid_q;

endmodule

// File: tb/tb_seg_display_sched.sv
// Scoreboard bench for seg_display_sched: a cycle-count reference model
// predicts every registered output; a monitor compares them each cycle.
module tb_seg_display_sched;

   localparam int unsigned TD    = 4;
   localparam int unsigned HOLD  = 3;
   localparam int unsigned BLINK = 1;
   localparam int unsigned GAPT  = 2;

   localparam int M_LIVE = 0;
   localparam int M_SHOW = 1;
   localparam int M_GAP  = 2;

   typedef struct {
      logic [31:0] d;
      logic [7:0]  v;
      logic        ack;
      logic        done;
      logic        busy;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] live_data = '0;
   logic [7:0]  live_valid = '0;
   logic        msg_req = 1'b0;
   logic [31:0] msg_data = '0;
   logic [7:0]  msg_valid = '0;
   logic        msg_blink = 1'b0;
   logic        msg_cancel = 1'b0;
   logic        msg_ack, msg_done, msg_busy;
   logic [31:0] output_data;
   logic [7:0]  output_valid;

   exp_t exp_q[$];
   bit   started = 0;
   int   total = 0;
   int   fails = 0;

   seg_display_sched #(
      .TICK_DIV    (TD),
      .HOLD_TICKS  (HOLD),
      .BLINK_TICKS (BLINK),
      .GAP_TICKS   (GAPT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .live_data    (live_data),
      .live_valid   (live_valid),
      .msg_req      (msg_req),
      .msg_data     (msg_data),
      .msg_valid    (msg_valid),
      .msg_blink    (msg_blink),
      .msg_cancel   (msg_cancel),
      .msg_ack      (msg_ack),
      .msg_done     (msg_done),
      .msg_busy     (msg_busy),
      .output_data  (output_data),
      .output_valid (output_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
      end
   endtask

   // Reference model: tracks cycles spent in each phase of a message.
   initial begin
      int          mode = M_LIVE;
      int unsigned el = 0;
      logic [31:0] md = '0;
      logic [7:0]  mv = '0;
      logic        mb = 1'b0;
      exp_t        e;
      forever begin
         @(posedge clk);
         e = '{d: 32'h0, v: 8'h0, ack: 1'b0, done: 1'b0, busy: 1'b0};
         if (!rst) begin
            mode = M_LIVE;
            el   = 0;
         end else begin
            case (mode)
               M_LIVE: begin
                  if (msg_req) begin
                     md = msg_data; mv = msg_valid; mb = msg_blink;
                     mode = M_SHOW; el = 0;
                     e.ack = 1'b1; e.d = md; e.v = mv;
                  end else begin
                     e.d = live_data; e.v = live_valid;
                  end
               end
               M_SHOW: begin
                  el++;
                  if (msg_cancel || el == HOLD * TD) begin
                     e.done = 1'b1;
                     el = 0;
                     mode = (GAPT == 0) ? M_LIVE : M_GAP;
                     if (mode == M_LIVE && !msg_req) begin
                        e.d = live_data; e.v = live_valid;
                     end else begin
                        e.d = md; e.v = 8'h00;
                     end
                  end else begin
                     e.d = md;
                     e.v = (mb && ((el / (BLINK * TD)) % 2 == 1)) ? 8'h00 : mv;
                  end
               end
               default: begin
                  el++;
                  if (el == GAPT * TD) begin
                     mode = M_LIVE; el = 0;
                     if (msg_req) begin
                        e.d = md; e.v = 8'h00;
                     end else begin
                        e.d = live_data; e.v = live_valid;
                     end
                  end else begin
                     e.d = md; e.v = 8'h00;
                  end
               end
            endcase
            e.busy = (mode != M_LIVE);
         end
         exp_q.push_back(e);
         started = 1;
      end
   end

   // Monitor: compares the outputs presented in each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (started) begin
            if (exp_q.size() == 0) begin
               chk("queue_empty", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("output_data", output_data, e.d);
               chk("output_valid", {24'h0, output_valid}, {24'h0, e.v});
               chk("msg_ack", {31'h0, msg_ack}, {31'h0, e.ack});
               chk("msg_done", {31'h0, msg_done}, {31'h0, e.done});
               chk("msg_busy", {31'h0, msg_busy}, {31'h0, e.busy});
            end
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ack();
      bit got = 0;
      for (int i = 0; i < 50; i++) begin
         cyc();
         if (msg_ack) begin
            got = 1;
            break;
         end
      end
      if (!got) chk("ack_timeout", 32'd0, 32'd1);
      msg_req = 1'b0;
   endtask

   task automatic wait_idle();
      bit got = 0;
      for (int i = 0; i < 100; i++) begin
         cyc();
         if (!msg_busy) begin
            got = 1;
            break;
         end
      end
      if (!got) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic send(input logic [31:0] d, input logic [7:0] v, input logic b);
      msg_data = d; msg_valid = v; msg_blink = b; msg_req = 1'b1;
   endtask

   // Stimulus: directed scenarios, then randomized traffic.
   initial begin
      live_data = 32'h1234_5678; live_valid = 8'hFF;
      rst = 1'b0;
      repeat (3) cyc();
      rst = 1'b1;
      repeat (3) cyc();

      send(32'hDEAD_BEEF, 8'h0F, 1'b0);
      wait_ack();
      wait_idle();
      repeat (3) cyc();

      send(32'hDEAD_BEEF, 8'h0F, 1'b1);
      wait_ack();
      wait_idle();
      repeat (2) cyc();

      send(32'hCAFE_0001, 8'hF0, 1'b0);
      wait_ack();
      repeat (4) cyc();
      msg_cancel = 1'b1;
      cyc();
      msg_cancel = 1'b0;
      wait_idle();
      repeat (2) cyc();

      send(32'hA5A5_0000, 8'h3C, 1'b1);
      for (int i = 0; i < 60; i++) begin
         cyc();
         live_data = $urandom;
         msg_data  = $urandom;
         msg_valid = 8'($urandom);
      end
      msg_req = 1'b0;
      wait_idle();
      repeat (2) cyc();

      send(32'h0BAD_F00D, 8'hFF, 1'b0);
      wait_ack();
      repeat (5) cyc();
      rst = 1'b0;
      repeat (2) cyc();
      rst = 1'b1;
      repeat (2) cyc();
      send(32'h7777_1111, 8'h81, 1'b0);
      wait_ack();
      wait_idle();

      for (int i = 0; i < 400; i++) begin
         live_data  = $urandom;
         live_valid = 8'($urandom);
         if (!msg_req && $urandom_range(0, 9) == 0) begin
            send($urandom, 8'($urandom), 1'($urandom));
         end
         msg_cancel = ($urandom_range(0, 15) == 0);
         cyc();
         if (msg_req && msg_ack) msg_req = 1'b0;
      end
      msg_req = 1'b0; msg_cancel = 1'b0;
      repeat (3) cyc();

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule

// File: doc/seg_display_sched.md
Name: seg_display_sched

Overview:
- Schedules what the 8-digit seven-segment driver shows.
- By default it passes through a "live" source, such as a running score or status word.
- A requester can pre-empt the live source with a timed message, optionally blinking, followed by a short blank gap before the live source returns.
- Sits directly upstream of the segment driver and produces its output_data/output_valid inputs.

Parameters:
- TICK_DIV, 100000: clock cycles per tick (1 ms at 100 MHz); must be >= 1.
- HOLD_TICKS, 2000: ticks a message stays on display; must be >= 1.
- BLINK_TICKS, 250: ticks per blink half-period; must be >= 1.
- GAP_TICKS, 100: ticks of blank display after a message; 0 means no gap.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-low reset.
- live_data, in, 32: eight 4-bit hex digits of the default source.
- live_valid, in, 8: per-digit enable of the default source.
- msg_req, in, 1: message request, level; held until msg_ack.
- msg_data, in, 32: message digits; sampled when accepted.
- msg_valid, in, 8: message digit enables; sampled when accepted.
- msg_blink, in, 1: blink the message; sampled when accepted.
- msg_cancel, in, 1: abort the current message; level, only honoured in SHOW.
- msg_ack, out, 1: one-cycle pulse, message accepted.
- msg_done, out, 1: one-cycle pulse, message finished or cancelled.
- msg_busy, out, 1: high whenever state != LIVE.
- output_data, out, 32: to the segment driver.
- output_valid, out, 8: to the segment driver.

Behaviour:
- rst low: state LIVE; output_data=0, output_valid=0, msg_ack=0, msg_done=0, msg_busy=0; all counters 0; latched message cleared.
- All outputs are registered. Each output is computed from the next state, so it changes on the same edge as the state.
- Tick prescaler:
  - Counts 0..TICK_DIV-1; tick is asserted in the cycle where the count equals TICK_DIV-1.
  - Restarts at 0 on every state entry.
- States: LIVE, SHOW, GAP.
- LIVE:
  - output_data/output_valid <= live_data/live_valid, one-cycle latency.
  - If msg_req=1 at edge k: latch msg_data/msg_valid/msg_blink, enter SHOW, and drive msg_ack=1 for the cycle after k.
  - output_data <= msg_data at that same edge k.
  - msg_cancel is ignored in LIVE.
- SHOW:
  - output_data holds the latched message.
  - output_valid = latched valid when the blink phase is "on", else 8'h00.
  - The blink phase starts "on" and toggles every BLINK_TICKS ticks; it is always "on" when msg_blink=0.
  - The hold counter increments per tick. On the tick where it reaches HOLD_TICKS-1, exit to GAP, or to LIVE if GAP_TICKS=0, and pulse msg_done.
  - SHOW therefore lasts exactly HOLD_TICKS*TICK_DIV cycles.
  - msg_cancel=1: exit on the next edge with a msg_done pulse.
  - Cancel coincident with hold expiry gives a single msg_done pulse.
  - msg_req is not acknowledged in SHOW.
- GAP:
  - output_valid=8'h00; output_data holds the message.
  - Lasts GAP_TICKS*TICK_DIV cycles, then goes to LIVE.
  - msg_req is not acknowledged in GAP. A held request is accepted on the first LIVE cycle; LIVE outputs for that cycle are skipped in favour of the message.
- msg_busy is registered and asserted on the same edge as the entry into SHOW.
- Reset mid-SHOW or mid-GAP: immediate return to reset values, no msg_done pulse.
- Counter widths: $clog2 of the respective maximum, minimum 1 bit; no wrap is reachable because each counter clears on state exit.

Decomposition:
- Package seg_ctrl_pkg holds:
  - state typedef (LIVE/SHOW/GAP);
  - constant SEG_BLANK_VALID = 8'h00;
  - a digit-count constant, 8.
- Sub-module seg_tick_gen: TICK_DIV prescaler with a restart input and a tick output.

Test Plan (TICK_DIV=4, HOLD_TICKS=3, BLINK_TICKS=1, GAP_TICKS=2):
1. Reset low, then release with live_data=32'h1234_5678, live_valid=8'hFF -> outputs are 0 during reset; one cycle after release they are 12345678/FF; busy=0.
2. msg_req with msg_data=32'hDEAD_BEEF, msg_valid=8'h0F, msg_blink=0 -> one-cycle ack; output DEADBEEF/0F for 12 cycles; one-cycle done; valid 00 for 8 cycles; then live 12345678/FF; busy high for 20 cycles.
3. Same as 2 with msg_blink=1 -> output_valid is 0F for 4 cycles, 00 for 4 cycles, 0F for 4 cycles, then the gap.
4. msg_cancel asserted in SHOW cycle 5 -> done on the next edge; valid 00 for 8 cycles; then live.
5. msg_req held continuously through SHOW and GAP -> exactly one ack per message; the second ack comes on the first LIVE cycle and the live value is never shown in between.
6. rst pulled low in SHOW cycle 6 -> outputs 0, busy 0, no done; after release, live data is shown and a new msg_req is acked normally.
